// File: rtl/mem_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: owns the MEM-stage data-memory handshake,
// freezes the pipeline while an access is outstanding, and merges that with load-use stalls and branch flushes.
module mem_stall_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        DMC_MEM,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              LdStall,
   input  logic              BrFlush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] rdata_q,
   output logic              PC_EN,
   output logic              IFID_EN,
   output logic              IDEX_EN,
   output logic              EXMEM_EN,
   output logic              IFID_flush,
   output logic              IDEX_flush,
   output logic              MEMWB_bubble,
   output logic              mem_err,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // Wait counter value on the last WAIT cycle allowed before declaring a timeout.
   localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [7:0]          r_wait_cnt;
   logic [7:0]          w_wait_cnt_next;
   logic                r_we_q;
   logic                w_we_q_next;
   logic [DATA_W-1:0]   r_rdata_q;
   logic                r_mem_err;
   logic [15:0]         r_stall_cnt;
   logic                w_access;
   logic                w_capture;
   logic                w_memstall;

   assign w_access = (DMC_MEM == 2'b01) || (DMC_MEM == 2'b10);

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_we_q_next     = r_we_q;
      w_capture       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               w_we_q_next     = (DMC_MEM == 2'b10);
               w_wait_cnt_next = 8'd0;
               w_state_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               w_capture    = ~r_we_q;
               w_state_next = S_DONE;
            end else if (r_wait_cnt == LP_WAIT_LAST) begin
               w_state_next = S_ERR;
            end else begin
               w_wait_cnt_next = r_wait_cnt + 8'd1;
            end
         end
         // DONE lets the frozen instruction leave MEM, so the access is never reissued.
         S_DONE:  w_state_next = S_IDLE;
         S_ERR:   w_state_next = S_ERR;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_memstall = ((r_state == S_IDLE) && w_access) ||
                       (r_state == S_WAIT) || (r_state == S_ERR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= 8'd0;
         r_we_q      <= 1'b0;
         r_rdata_q   <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_we_q     <= w_we_q_next;
         if (w_capture) begin
            r_rdata_q <= mem_rdata;
         end
         if (w_state_next == S_ERR) begin
            r_mem_err <= 1'b1;
         end
         if (w_memstall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   // Pipeline control, highest priority first: reset, memory freeze, branch flush, load-use stall.
   always_comb begin
      PC_EN        = 1'b1;
      IFID_EN      = 1'b1;
      IDEX_EN      = 1'b1;
      EXMEM_EN     = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      MEMWB_bubble = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      if (rst) begin
         PC_EN    = 1'b0;
         IFID_EN  = 1'b0;
         IDEX_EN  = 1'b0;
         EXMEM_EN = 1'b0;
      end else begin
         mem_req = (r_state == S_WAIT);
         mem_we  = (r_state == S_WAIT) && r_we_q;
         if (w_memstall) begin
            PC_EN        = 1'b0;
            IFID_EN      = 1'b0;
            IDEX_EN      = 1'b0;
            EXMEM_EN     = 1'b0;
            MEMWB_bubble = 1'b1;
         end else if (BrFlush) begin
            IFID_flush = 1'b1;
         end else if (LdStall) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IDEX_flush = 1'b1;
         end
      end
   end

   assign rdata_q   = r_rdata_q;
   assign mem_err   = r_mem_err;
   assign stall_cnt = r_stall_cnt;

endmodule
